hpb_cfg_fifo: RTL

Parametrised host-config buffer and channel dispatcher in the core clock domain, placed after the host-interface synchroniser. It buffers config words arriving on a valid/accept handshake in a DEPTH-entry FIFO. It decodes a channel field in each word and presents the word to exactly one of N_CH downstream config consumers, each with its own valid/accept. Words carrying an out-of-range channel ID are discarded and counted.

---
 rtl/hpb_cfg_fifo.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/hpb_cfg_fifo.sv
// hpb_cfg_fifo: host-config buffer and channel dispatcher (core clock domain).
//
// Buffers config words from the upstream valid/accept handshake in a
// DEPTH-entry circular FIFO. It decodes the channel field of the head word
// and offers that word to exactly one of N_CH downstream consumers. A head
// word whose channel ID is >= N_CH is popped without being presented.
//
// Optional feature macro: HPB_CFG_DROP_CNT_EN
//   defined   -> drop_count is a 16-bit saturating count of discarded words
//   undefined -> drop_count is tied to 0 (bad words are still discarded)
//
// Ports:
//   clk                in   core clock
//   reset              in   synchronous active-high reset
//   in_config_valid    in   upstream word valid
//   in_config_data     in   upstream word (DATA_W)
//   in_config_accept   out  upstream may transfer this cycle (not full)
//   out_config_valid   out  one-hot valid for the head word's channel (N_CH)
//   out_config_data    out  head word, shared by all channels (DATA_W)
//   out_config_accept  in   per-channel accept (N_CH)
//   fifo_count         out  current occupancy
//   drop_count         out  discarded-word counter, saturating at 0xFFFF

module hpb_cfg_fifo #(
    parameter int unsigned DATA_W = 256,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned N_CH   = 2,
    parameter int unsigned CH_LSB = 248
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_config_valid,
    input  logic [DATA_W-1:0]            in_config_data,
    output logic                         in_config_accept,
    output logic [N_CH-1:0]              out_config_valid,
    output logic [DATA_W-1:0]            out_config_data,
    input  logic [N_CH-1:0]              out_config_accept,
    output logic [$clog2(DEPTH+1)-1:0]   fifo_count,
    output logic [15:0]                  drop_count
);

    localparam int unsigned CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    // Storage and state
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q,  count_d;

    // Registered output view of the head word
    logic [DATA_W-1:0] head_q,     head_d;
    logic [N_CH-1:0]   valid_q,    valid_d;
    logic              head_bad_q, head_bad_d;
    logic              accept_q,   accept_d;

    logic              push;
    logic              pop_good;
    logic              pop;
    logic [CH_W-1:0]   ch_d;
    logic              ch_ok_d;

    // Handshake decode; accept bits of non-valid channels are masked off
    always_comb begin
        push     = in_config_valid && accept_q;
        pop_good = |(valid_q & out_config_accept);
        pop      = pop_good || head_bad_q;
    end

    // Next-state for pointers, occupancy and the presented head word.
    // The head is precomputed one cycle early so all outputs are flops;
    // a word written this cycle into the slot that becomes the head is
    // forwarded straight from the input.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        head_d     = head_q;
        ch_d       = '0;
        ch_ok_d    = 1'b0;
        valid_d    = '0;
        head_bad_d = 1'b0;
        accept_d   = 1'b1;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (!push && pop) begin
            count_d = count_q - CNT_W'(1);
        end

        // Empty: hold the last head value
        if (count_d != '0) begin
            if (push && (rd_ptr_d == wr_ptr_q)) begin
                head_d = in_config_data;
            end else begin
                head_d = mem_q[rd_ptr_d];
            end
        end

        ch_d    = head_d[CH_LSB +: CH_W];
        ch_ok_d = (32'(ch_d) < 32'(N_CH));

        if (count_d != '0) begin
            if (ch_ok_d) begin
                valid_d = N_CH'(1) << ch_d;
            end else begin
                head_bad_d = 1'b1;
            end
        end

        accept_d = (count_d != CNT_W'(DEPTH));
    end

    // State registers
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            head_q     <= '0;
            valid_q    <= '0;
            head_bad_q <= 1'b0;
            accept_q   <= 1'b1;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            head_q     <= head_d;
            valid_q    <= valid_d;
            head_bad_q <= head_bad_d;
            accept_q   <= accept_d;
        end
    end

    // Storage write; contents need no reset since pointers/count do
    always_ff @(posedge clk) begin
        if (!reset && push) begin
            mem_q[wr_ptr_q] <= in_config_data;
        end
    end

`ifdef HPB_CFG_DROP_CNT_EN
    logic [15:0] drop_q;

    // Saturating count of auto-popped bad words
    always_ff @(posedge clk) begin
        if (reset) begin
            drop_q <= '0;
        end else if (head_bad_q && (drop_q != 16'hFFFF)) begin
            drop_q <= drop_q + 16'd1;
        end
    end

    assign drop_count = drop_q;
`else
    assign drop_count = '0;
`endif

    assign in_config_accept = accept_q;
    assign out_config_valid = valid_q;
    assign out_config_data  = head_q;
    assign fifo_count       = count_q;

endmodule
